seq_mul: RTL and testbench

Iterative radix-2 shift-add multiplier with WIDTH-bit operands and a 2·WIDTH-bit product. Operands are accepted and products returned over valid/ready handshakes. It trades the area of the combinational array multiplier for a latency of WIDTH cycles. It sits in the lab datapath library as the parametrised, sequential generation of the 8x8 array multiplier and targets designs where area matters more than throughput.

---
 rtl/seq_mul_pkg.sv | 8 +
 rtl/seq_mul_step.sv | 18 +
 rtl/seq_mul.sv | 60 ++++++
 tb/tb_seq_mul.sv | 129 ++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: FSM state encoding and counter width helper shared by seq_mul and seq_mul_step
package seq_mul_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/seq_mul_step.sv
// seq_mul_step: one add/subtract-and-shift step; ports acc, mcand, sgn (two's complement), last (final step subtracts when signed) -> acc_nxt
module seq_mul_step #(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mcand,
  input  logic               sgn,
  input  logic               last,
  output logic [2*WIDTH-1:0] acc_nxt
);
  logic [WIDTH:0] upper, addend, partial;
  always_comb begin
    upper   = {sgn & acc[2*WIDTH-1], acc[2*WIDTH-1:WIDTH]};
    addend  = acc[0] ? {sgn & mcand[WIDTH-1], mcand} : '0;
    partial = (sgn && last) ? upper - addend : upper + addend;
    acc_nxt = {partial, acc[WIDTH-1:1]};
  end
endmodule

// File: rtl/seq_mul.sv
// seq_mul: WIDTH-cycle radix-2 shift-add multiplier; ports clk, rst (async high), in_valid/in_ready/x/y, tc (only with SEQ_MUL_SIGNED_EN), out_valid/out_ready/p, busy
module seq_mul
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
`ifdef SEQ_MUL_SIGNED_EN
  input  logic               tc,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);
  localparam int CW = cnt_w(WIDTH);
  state_t             state;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   mcand;
  logic [CW-1:0]      cnt;
  logic               sgn, last;
`ifdef SEQ_MUL_SIGNED_EN
  logic tc_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) tc_q <= 1'b0;
    else if (state == IDLE && in_valid) tc_q <= tc;
  assign sgn = tc_q;
`else
  assign sgn = 1'b0;
`endif
  assign last      = cnt == CW'(WIDTH - 1);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state == RUN;
  assign p         = acc;
  seq_mul_step #(.WIDTH(WIDTH)) u_step (
    .acc(acc), .mcand(mcand), .sgn(sgn), .last(last), .acc_nxt(acc_nxt)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      mcand <= '0;
      cnt   <= '0;
    end else if (state == IDLE && in_valid) begin
      state <= RUN;
      mcand <= x;
      acc   <= {{WIDTH{1'b0}}, y};
      cnt   <= '0;
    end else if (state == RUN) begin
      acc   <= acc_nxt;
      cnt   <= cnt + CW'(1);
      state <= last ? DONE : RUN;
    end else if (state == DONE && out_ready) state <= IDLE;
endmodule

// File: tb/tb_seq_mul.sv
// tb_seq_mul: directed and random checks of seq_mul at WIDTH 4, 8 and 16
module tb_seq_mul;
  logic        clk = 1'b0, rst = 1'b1;
  logic [2:0]  iv = '0, orr = '0, ir, ov, bz;
  logic [3:0]  x4 = '0, y4 = '0;
  logic [7:0]  x8 = '0, y8 = '0, p4;
  logic [15:0] x16 = '0, y16 = '0, p8;
  logic [31:0] p16;
`ifdef SEQ_MUL_SIGNED_EN
  logic tc = 1'b0;
`endif
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  seq_mul #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .x(x4), .y(y4),
`ifdef SEQ_MUL_SIGNED_EN
    .tc(1'b0),
`endif
    .out_valid(ov[0]), .out_ready(orr[0]), .p(p4), .busy(bz[0]));
  seq_mul #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .x(x8), .y(y8),
`ifdef SEQ_MUL_SIGNED_EN
    .tc(tc),
`endif
    .out_valid(ov[1]), .out_ready(orr[1]), .p(p8), .busy(bz[1]));
  seq_mul #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .x(x16), .y(y16),
`ifdef SEQ_MUL_SIGNED_EN
    .tc(1'b0),
`endif
    .out_valid(ov[2]), .out_ready(orr[2]), .p(p16), .busy(bz[2]));
  function automatic logic [31:0] getp(input int i);
    return i == 0 ? {24'b0, p4} : i == 1 ? {16'b0, p8} : p16;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_xy(input int i, input logic [15:0] a, input logic [15:0] b);
    if (i == 0) begin x4 = a[3:0]; y4 = b[3:0]; end
    else if (i == 1) begin x8 = a[7:0]; y8 = b[7:0]; end
    else begin x16 = a; y16 = b; end
  endtask
  task automatic mul(input int i, input logic [15:0] a, input logic [15:0] b,
                     input logic [31:0] exp, input int stall, input string tag);
    int w, n;
    w = i == 0 ? 4 : i == 1 ? 8 : 16;
    @(negedge clk);
    set_xy(i, a, b);
    iv[i] = 1'b1;
    @(posedge clk); #1;
    iv[i] = 1'b0;
    chk({tag, "_busy"}, {31'b0, bz[i]}, 32'd1);
    n = 0;
    while (!ov[i] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, w);
    chk({tag, "_p"}, getp(i), exp);
    for (int s = 0; s < stall; s++) begin
      set_xy(i, ~a, ~b);
      iv[i] = s[0];
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, {31'b0, ov[i]}, 32'd1);
      chk({tag, "_hold_p"}, getp(i), exp);
      chk({tag, "_hold_ready"}, {31'b0, ir[i]}, 32'd0);
    end
    iv[i] = stall > 0;
    orr[i] = 1'b1;
    @(posedge clk); #1;
    orr[i] = 1'b0;
    iv[i] = 1'b0;
    chk({tag, "_ready_after"}, {29'b0, ir[i], ov[i], bz[i]}, 32'b100);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] a, b, m;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_flags", {29'b0, ir[1], ov[1], bz[1]}, 32'b100);
    chk("reset_p", {16'b0, p8}, 32'h0);
    mul(1, 16'hFF, 16'hFF, 32'hFE01, 0, "ff_ff");
    mul(1, 16'h00, 16'hA5, 32'h0000, 0, "zero");
    mul(1, 16'h01, 16'hA5, 32'h00A5, 0, "ident");
    mul(1, 16'h0D, 16'h0B, 32'h008F, 5, "backpressure");
`ifdef SEQ_MUL_SIGNED_EN
    tc = 1'b1;
    mul(1, 16'h80, 16'h80, 32'h4000, 0, "s_80_80");
    mul(1, 16'hFF, 16'h01, 32'hFFFF, 0, "s_ff_01");
    mul(1, 16'h7F, 16'h80, 32'hC080, 0, "s_7f_80");
    tc = 1'b0;
`endif
    mul(1, 16'h80, 16'h80, 32'h4000, 0, "u_80_80");
    mul(1, 16'hFF, 16'h01, 32'h00FF, 0, "u_ff_01");
    mul(1, 16'h7F, 16'h80, 32'h3F80, 0, "u_7f_80");
    @(negedge clk);
    x8 = 8'hFF; y8 = 8'hFF; iv[1] = 1'b1;
    @(posedge clk); #1;
    iv[1] = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrun_flags", {29'b0, ir[1], ov[1], bz[1]}, 32'b100);
    chk("midrun_p", {16'b0, p8}, 32'h0);
    @(negedge clk) rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("midrun_no_valid", {31'b0, ov[1]}, 32'd0);
    mul(1, 16'd3, 16'd5, 32'd15, 0, "after_reset");
    for (int i = 0; i < 3; i++) begin
      m = i == 0 ? 32'hF : i == 1 ? 32'hFF : 32'hFFFF;
      for (int k = 0; k < 12; k++) begin
        a = $urandom & m;
        b = $urandom & m;
        mul(i, a[15:0], b[15:0], a * b, k < 6 ? 0 : int'($urandom_range(0, 3)), $sformatf("rand_w%0d_%0d", i, k));
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
